mem_port_arbiter: RTL

Arbitrates the single shared program/data memory port between the instruction-fetch unit and the LDR/STR load-store unit of the 16-bit core. Each cycle it grants at most one requester, drives the memory address/enable/write controls, and routes the synchronous read data back to the requester that issued it. Data accesses normally win; a starvation counter guarantees forward progress for fetch, and a flush input discards in-flight fetch responses on a taken jump.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch unit, the load/store unit, the shared memory and
// mem_port_arbiter. The arbiter takes the slave view; the core side takes master.
interface mem_port_arbiter_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16
);
  logic              if_req;
  logic [AWIDTH-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DWIDTH-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [AWIDTH-1:0] ls_addr;
  logic [DWIDTH-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DWIDTH-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, if_flush, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, if_flush, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store: data
// wins by default, a burst counter guarantees fetch progress, and a 2-stage tag
// pipeline steers synchronous read data back to its requester.
module mem_port_arbiter #(
  parameter int DWIDTH         = 16,
  parameter int AWIDTH         = 16,
  parameter int MAX_DATA_BURST = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_DATA  = 2'd2
  } tag_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  logic [3:0]        r_burst_cnt;
  tag_e              r_tag;
  logic              r_if_rvalid;
  logic              r_ls_rvalid;
  logic [DWIDTH-1:0] r_if_rdata;
  logic [DWIDTH-1:0] r_ls_rdata;

  logic              w_fetch_ok;
  logic              w_if_gnt;
  logic              w_ls_gnt;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [AWIDTH-1:0] w_mem_addr;
  logic [DWIDTH-1:0] w_mem_wdata;
  tag_e              w_tag_next;
  logic              w_if_land;
  logic              w_ls_land;

  // Grant decision: data has priority until it has starved fetch for
  // MAX_DATA_BURST consecutive grants.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_if_gnt   = 1'b0;
    w_ls_gnt   = 1'b0;
    w_fetch_ok = bus.if_req & ~bus.if_flush;
    if (bus.ls_req && w_fetch_ok) begin
      if (r_burst_cnt == BURST_MAX) w_if_gnt = 1'b1;
      else                          w_ls_gnt = 1'b1;
    end else begin
      w_if_gnt = w_fetch_ok;
      w_ls_gnt = bus.ls_req;
    end
  end

  always_comb begin
    w_mem_en    = w_if_gnt | w_ls_gnt;
    w_mem_we    = w_ls_gnt & bus.ls_we;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_tag_next  = TAG_NONE;
    if (w_ls_gnt) begin
      w_mem_addr  = bus.ls_addr;
      w_mem_wdata = bus.ls_wdata;
      if (!bus.ls_we) w_tag_next = TAG_DATA;
    end else if (w_if_gnt) begin
      w_mem_addr = bus.if_addr;
      w_tag_next = TAG_FETCH;
    end
  end

  // A flush in the cycle the fetch data returns from memory kills that response.
  assign w_if_land = (r_tag == TAG_FETCH) && !bus.if_flush;
  assign w_ls_land = (r_tag == TAG_DATA);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_burst_cnt <= '0;
    end else if (w_if_gnt || !w_fetch_ok) begin
      r_burst_cnt <= '0;
    end else if (w_ls_gnt && r_burst_cnt != BURST_MAX) begin
      r_burst_cnt <= r_burst_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all response state, including the rdata holding registers, is reset so a
    // mid-operation reset leaves nothing in flight and no stale data visible.
    if (rst) begin
      r_tag       <= TAG_NONE;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      r_tag       <= w_tag_next;
      r_if_rvalid <= w_if_land;
      r_ls_rvalid <= w_ls_land;
      if (w_if_land) r_if_rdata <= bus.mem_rdata;
      if (w_ls_land) r_ls_rdata <= bus.mem_rdata;
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.ls_gnt    = w_ls_gnt;
  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_rvalid = r_ls_rvalid;
  assign bus.ls_rdata  = r_ls_rdata;

endmodule
